// File: rtl/ucsbece154a_multicycle_controller.sv
// ucsbece154a_multicycle_controller
//   Multicycle RV32I control unit: a state register plus ALU decoder that
//   drives the mux selects and write enables of a shared-memory datapath.
//   Supports a memory wait-state handshake, optional bne, a retired-
//   instruction counter and a sticky illegal-instruction flag.
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   op_i, funct3_i        opcode / funct3 fields from the instruction register
//   funct7b5_i            IR bit 30 (selects sub for R-type funct3=000)
//   zero_i                ALU zero flag, used for branch resolution
//   mem_ready_i           memory access completes this cycle
//   PCWrite_o .. RegWrite_o  datapath enables and selects
//   state_o               current state encoding (debug)
//   instret_o             retired-instruction count, wraps
//   illegal_o             sticky unsupported opcode/funct3 flag
module ucsbece154a_multicycle_controller #(
  parameter bit EN_BNE       = 1'b1,
  parameter bit EN_MEM_STALL = 1'b1,
  parameter int INSTR_CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             op_i,
  input  logic [2:0]             funct3_i,
  input  logic                   funct7b5_i,
  input  logic                   zero_i,
  input  logic                   mem_ready_i,
  output logic                   PCWrite_o,
  output logic                   AdrSrc_o,
  output logic                   MemWrite_o,
  output logic                   IRWrite_o,
  output logic [1:0]             ResultSrc_o,
  output logic [1:0]             ALUSrcA_o,
  output logic [1:0]             ALUSrcB_o,
  output logic [2:0]             ALUControl_o,
  output logic [2:0]             ImmSrc_o,
  output logic                   RegWrite_o,
  output logic [3:0]             state_o,
  output logic [INSTR_CNT_W-1:0] instret_o,
  output logic                   illegal_o
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_LUI = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  state_t     state, next_state;
  logic       ready, is_bne, br_ok, alu_f3_ok;
  logic       pc_update, branch, ir_write, reg_write, mem_write;
  logic [1:0] alu_op;
  logic       set_illegal, retire;
  // Marks an instruction already flagged illegal in EXEC so its ALUWB exit
  // is not counted as retired.
  logic       instr_bad;

  assign ready     = EN_MEM_STALL ? mem_ready_i : 1'b1;
  assign is_bne    = (funct3_i == 3'b001);
  assign br_ok     = (funct3_i == 3'b000) || (is_bne && EN_BNE);
  assign alu_f3_ok = (funct3_i == 3'b000) || (funct3_i == 3'b010) ||
                     (funct3_i == 3'b110) || (funct3_i == 3'b111);

  // State-driven outputs and next-state logic.
  // NOTE: every signal written here gets a default first, otherwise an
  // unlisted state path would infer a latch.
  always_comb begin
    next_state  = S_FETCH;
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    AdrSrc_o    = 1'b0;
    ResultSrc_o = 2'b00;
    ALUSrcA_o   = 2'b00;
    ALUSrcB_o   = 2'b00;
    alu_op      = 2'b00;
    set_illegal = 1'b0;
    retire      = 1'b0;
    unique case (state)
      S_FETCH: begin
        ir_write    = ready;
        pc_update   = ready;
        ALUSrcB_o   = 2'b10;
        ResultSrc_o = 2'b10;
        next_state  = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b01;
        case (op_i)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BR:        next_state = S_BRANCH;
          OP_JAL:       next_state = S_JAL;
          OP_LUI:       next_state = S_LUI;
          default:      set_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA_o  = 2'b10;
        ALUSrcB_o  = 2'b01;
        next_state = (op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc_o   = 1'b1;
        next_state = ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc_o = 2'b01;
        reg_write   = 1'b1;
        retire      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc_o   = 1'b1;
        mem_write  = 1'b1;
        retire     = ready;
        next_state = ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA_o   = 2'b10;
        ALUSrcB_o   = (state == S_EXECI) ? 2'b01 : 2'b00;
        alu_op      = 2'b10;
        set_illegal = !alu_f3_ok;
        next_state  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = !instr_bad;
      end
      S_BRANCH: begin
        ALUSrcA_o   = 2'b10;
        alu_op      = 2'b01;
        branch      = br_ok;
        set_illegal = !br_ok;
        retire      = br_ok;
      end
      S_JAL: begin
        ALUSrcA_o  = 2'b01;
        ALUSrcB_o  = 2'b10;
        pc_update  = 1'b1;
        next_state = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA_o  = 2'b11;
        ALUSrcB_o  = 2'b01;
        next_state = S_ALUWB;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // ALU decoder.
  always_comb begin
    ALUControl_o = 3'b000;
    case (alu_op)
      2'b01: ALUControl_o = 3'b001;
      2'b10: case (funct3_i)
               3'b000:  ALUControl_o = (funct7b5_i & op_i[5]) ? 3'b001 : 3'b000;
               3'b010:  ALUControl_o = 3'b101;
               3'b110:  ALUControl_o = 3'b011;
               3'b111:  ALUControl_o = 3'b010;
               default: ALUControl_o = 3'b000;
             endcase
      default: ALUControl_o = 3'b000;
    endcase
  end

  // Immediate format straight from the opcode.
  always_comb begin
    case (op_i)
      OP_LW, OP_I: ImmSrc_o = 3'b000;
      OP_SW:       ImmSrc_o = 3'b001;
      OP_BR:       ImmSrc_o = 3'b010;
      OP_JAL:      ImmSrc_o = 3'b011;
      OP_LUI:      ImmSrc_o = 3'b100;
      default:     ImmSrc_o = 3'bxxx;
    endcase
  end

  // Reset parks the FSM in FETCH, whose enables are active; mask every write
  // enable with reset so nothing can pulse while reset is held.
  assign PCWrite_o  = (pc_update | (branch & (zero_i ^ is_bne))) & ~reset;
  assign IRWrite_o  = ir_write  & ~reset;
  assign RegWrite_o = reg_write & ~reset;
  assign MemWrite_o = mem_write & ~reset;
  assign state_o    = state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      instret_o <= '0;
      illegal_o <= 1'b0;
      instr_bad <= 1'b0;
    end else begin
      state <= next_state;
      if (retire)      instret_o <= instret_o + INSTR_CNT_W'(1);
      if (set_illegal) illegal_o <= 1'b1;
      if (state == S_FETCH) instr_bad <= 1'b0;
      else if (set_illegal) instr_bad <= 1'b1;
    end
  end

endmodule
